spram_ctrl: RTL and testbench

SPRAM_CTRL -- requirements
Module: spram_ctrl

---
 rtl/spram_ctrl.sv | 95 +++++++++
 tb/tb_spram_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_ctrl.sv
// Single-port RAM controller: round-robin write/read arbitration onto one RAM port,
// with a 2-entry in-order response FIFO fed by the RAM's registered read data.
module spram_ctrl #(
  parameter int dwidth = 8,
  parameter int awidth = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [awidth-1:0] wr_addr,
  input  logic [dwidth-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [awidth-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rsp_valid,
  output logic [dwidth-1:0] rsp_data,
  input  logic              rsp_ready,
  output logic [dwidth-1:0] mem_din,
  output logic [awidth-1:0] mem_addr,
  output logic              mem_wr,
  input  logic [dwidth-1:0] mem_dout
);

  typedef enum logic {PRI_WR, PRI_RD} pri_t;

  pri_t              pri, pri_nxt;
  logic              inflight;
  logic [dwidth-1:0] fifo [2];
  logic              wptr, rptr;
  logic [1:0]        count;
  logic              pop, push;
  logic [2:0]        occupancy;
  logic              wr_elig, rd_elig;

  // Reads are throttled so that FIFO entries plus the read in flight never exceed two.
  assign rsp_valid = rst_n && (count != 2'd0);
  assign rsp_data  = rsp_valid ? fifo[rptr] : '0;
  assign pop       = rsp_valid && rsp_ready;
  assign push      = inflight;
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign wr_elig   = rst_n && wr_req;
  assign rd_elig   = rst_n && rd_req && (occupancy < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pri <= PRI_WR;
    else        pri <= pri_nxt;
  end

  always_comb begin
    pri_nxt = pri;
    if (wr_elig && rd_elig)
      pri_nxt = (pri == PRI_WR) ? PRI_RD : PRI_WR;
  end

  always_comb begin
    wr_ack   = 1'b0;
    rd_ack   = 1'b0;
    if (wr_elig && rd_elig) begin
      wr_ack = (pri == PRI_WR);
      rd_ack = (pri == PRI_RD);
    end else begin
      wr_ack = wr_elig;
      rd_ack = rd_elig;
    end
    mem_wr   = wr_ack;
    mem_addr = '0;
    mem_din  = '0;
    if (wr_ack) begin
      mem_addr = wr_addr;
      mem_din  = wr_data;
    end else if (rd_ack) begin
      mem_addr = rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      count    <= '0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
    end else begin
      inflight <= rd_ack;
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wptr] <= mem_dout;
  end

endmodule

// File: tb/tb_spram_ctrl.sv
// Self-checking bench for spram_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized handshaked traffic.
module tb_spram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_req = 1'b0, rd_req = 1'b0, rsp_ready = 1'b0;
  logic [7:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
  logic       wr_ack, rd_ack, rsp_valid, mem_wr;
  logic [7:0] rsp_data, mem_din, mem_addr;
  logic [7:0] mem_dout = '0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  spram_ctrl #(.dwidth(8), .awidth(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .mem_din(mem_din), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment RAM: registered read, output held across write cycles.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_din;
    else        mem_dout <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: pending responses as a queue, one read in flight, shadow memory.
  logic [7:0] mq [$];
  logic [7:0] shadow [256];
  bit         m_inf = 1'b0;
  logic [7:0] m_inf_data = '0;
  bit         m_pri_wr = 1'b1;
  bit         e_pop, e_wr, e_rd;
  logic [7:0] e_addr, e_din;

  always @(negedge clk) begin
    chk("mem_wr_known", {31'b0, $isunknown(mem_wr)}, 0);
    if (!rst_n) begin
      chk("rst_wr_ack", wr_ack, 0);
      chk("rst_rd_ack", rd_ack, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_din", mem_din, 0);
      mq.delete();
      m_inf = 1'b0;
      m_pri_wr = 1'b1;
    end else begin
      e_pop = (mq.size() > 0) && rsp_ready;
      e_wr  = wr_req;
      e_rd  = rd_req && ((mq.size() + int'(m_inf) - int'(e_pop)) < 2);
      if (e_wr && e_rd) begin
        if (m_pri_wr) e_rd = 1'b0;
        else          e_wr = 1'b0;
        m_pri_wr = !m_pri_wr;
      end
      e_addr = e_wr ? wr_addr : (e_rd ? rd_addr : 8'h00);
      e_din  = e_wr ? wr_data : 8'h00;
      chk("wr_ack", wr_ack, e_wr);
      chk("rd_ack", rd_ack, e_rd);
      chk("mem_wr", mem_wr, e_wr);
      chk("mem_addr", mem_addr, e_addr);
      if (!e_rd) chk("mem_din", mem_din, e_din);
      chk("rsp_valid", rsp_valid, mq.size() > 0);
      if (mq.size() > 0) chk("rsp_data", rsp_data, mq[0]);
      if (e_pop) void'(mq.pop_front());
      if (m_inf) mq.push_back(m_inf_data);
      m_inf = e_rd;
      if (e_rd) m_inf_data = shadow[rd_addr];
      if (e_wr) shadow[wr_addr] = wr_data;
    end
  end

  // Stimulus tasks are entered and left 1 time unit after a posedge.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    int unsigned n = 0;
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    forever begin
      @(negedge clk);
      if (wr_ack) break;
      n++;
      if (n > 50) begin chk("wr_timeout", 1, 0); break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    wr_req = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, output int ack_cyc);
    int unsigned n = 0;
    rd_req = 1'b1; rd_addr = a; ack_cyc = -1;
    forever begin
      @(negedge clk);
      if (rd_ack) begin ack_cyc = cyc; break; end
      n++;
      if (n > 50) begin chk("rd_timeout", 1, 0); break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic wait_rsp(output int rcyc, output logic [7:0] d);
    int unsigned n = 0;
    rcyc = -1; d = '0;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin rcyc = cyc; d = rsp_data; break; end
      n++;
      if (n > 50) begin chk("rsp_timeout", 1, 0); break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int         c0, c1, acks, got, first_ack, last_ack, first_rsp, last_rsp;
    logic [3:0] wseq, rseq, mseq;
    logic [7:0] d;
    logic [7:0] pops [$];
    logic [7:0] exp3 [3];
    logic       wa, ra;

    for (int i = 0; i < 256; i++) begin ram[i] = 8'h00; shadow[i] = 8'h00; end
    #1;
    chk("t0_mem_wr", {31'b0, mem_wr}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Write then read back one location.
    rsp_ready = 1'b1;
    do_write(8'h10, 8'hA5);
    do_read(8'h10, c0);
    wait_rsp(c1, d);
    chk("a5_latency", c1 - c0, 2);
    chk("a5_data", d, 8'hA5);

    // Both requesters held from reset: strict alternation starting with write.
    @(posedge clk); #1 rst_n = 1'b0;
    idle(2);
    wr_req = 1'b1; wr_addr = 8'h20; wr_data = 8'h5A;
    rd_req = 1'b1; rd_addr = 8'h20; rst_n = 1'b1;
    wseq = '0; rseq = '0; mseq = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wseq = {wseq[2:0], wr_ack}; rseq = {rseq[2:0], rd_ack}; mseq = {mseq[2:0], mem_wr};
      @(posedge clk); #1;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    chk("rr_wr_seq", wseq, 4'b1010);
    chk("rr_rd_seq", rseq, 4'b0101);
    chk("rr_mem_wr_seq", mseq, 4'b1010);
    idle(4);

    // Backpressure: only two reads accepted until the consumer drains.
    do_write(8'h01, 8'h11); do_write(8'h02, 8'h22); do_write(8'h03, 8'h33);
    rsp_ready = 1'b0; rd_req = 1'b1; rd_addr = 8'h01; acks = 0;
    exp3 = '{8'h11, 8'h22, 8'h33};
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 6) begin
        chk("bp_acks_held", acks, 2);
        chk("bp_valid_held", rsp_valid, 1);
        chk("bp_data_held", rsp_data, 8'h11);
      end
      if (rsp_valid && rsp_ready) pops.push_back(rsp_data);
      got = rd_ack;
      if (rd_ack) acks++;
      @(posedge clk); #1;
      if (got != 0) begin
        if (acks == 3) rd_req = 1'b0;
        else rd_addr = 8'(acks + 1);
      end
      if (c == 6) rsp_ready = 1'b1;
    end
    chk("bp_acks_total", acks, 3);
    chk("bp_pop_count", pops.size(), 3);
    for (int i = 0; i < pops.size() && i < 3; i++) chk("bp_pop_data", pops[i], exp3[i]);

    // Back-to-back streaming reads.
    for (int i = 0; i < 8; i++) do_write(8'(i), 8'(8'h40 + i));
    rsp_ready = 1'b1; rd_req = 1'b1; rd_addr = 8'h00;
    acks = 0; pops.delete(); first_ack = -1; last_ack = -1; first_rsp = -1; last_rsp = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        pops.push_back(rsp_data);
        if (first_rsp < 0) first_rsp = cyc;
        last_rsp = cyc;
      end
      got = rd_ack;
      if (rd_ack) begin
        acks++;
        if (first_ack < 0) first_ack = cyc;
        last_ack = cyc;
      end
      @(posedge clk); #1;
      if (got != 0) begin
        if (acks == 8) rd_req = 1'b0;
        else rd_addr = 8'(acks);
      end
    end
    chk("s_acks", acks, 8);
    chk("s_ack_span", last_ack - first_ack, 7);
    chk("s_rsp_count", pops.size(), 8);
    chk("s_rsp_span", last_rsp - first_rsp, 7);
    chk("s_first_latency", first_rsp - first_ack, 2);
    for (int i = 0; i < pops.size() && i < 8; i++) chk("s_rsp_data", pops[i], 8'(8'h40 + i));

    // Reset while a read is in flight discards it.
    do_read(8'h05, c0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) acks++;
      @(posedge clk); #1;
    end
    chk("rst_no_rsp", acks, 0);
    do_read(8'h05, c0);
    wait_rsp(c1, d);
    chk("rst_resume_latency", c1 - c0, 2);
    chk("rst_resume_data", d, 8'h45);

    // Randomized handshaked traffic over a small address window.
    wa = 1'b0; ra = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      wa = wr_ack; ra = rd_ack;
      @(posedge clk); #1;
      if (!wr_req || wa) begin
        wr_req = ($urandom_range(0, 2) == 0); wr_addr = 8'($urandom_range(0, 15)); wr_data = 8'($urandom);
      end
      if (!rd_req || ra) begin
        rd_req = ($urandom_range(0, 1) == 1); rd_addr = 8'($urandom_range(0, 15));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    wr_req = 1'b0; rd_req = 1'b0; rsp_ready = 1'b1;
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
